// File: rtl/seq_signed_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master issues start with operands; the slave (the divider) returns results.
interface seq_signed_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Restoring shift-subtract signed divider, one quotient bit per clock.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module seq_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_signed_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic             sign_a_reg, sign_a_next;
  logic             sign_b_reg, sign_b_next;
  logic             zero_reg, zero_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dsr_reg, dsr_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             dbz_reg, dbz_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] remo_reg, remo_next;

  // dvd_reg starts as the dividend magnitude and fills with quotient bits from the right.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign trial   = {rem_reg, dvd_reg[WIDTH-1]} - {2'b00, dsr_reg};

  always_comb begin
    state_next  = state_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    zero_next   = zero_reg;
    dvd_next    = dvd_reg;
    dsr_next    = dsr_reg;
    rem_next    = rem_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    dbz_next    = dbz_reg;
    quo_next    = quo_reg;
    remo_next   = remo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          sign_a_next = bus.dividend[WIDTH-1];
          sign_b_next = bus.divisor[WIDTH-1];
          dvd_next    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          dsr_next    = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
          rem_next    = '0;
          cnt_next    = '0;
          zero_next   = (bus.divisor == '0);
          busy_next   = 1'b1;
          state_next  = (bus.divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        if (!trial[WIDTH+1]) begin
          rem_next = trial[WIDTH:0];
          dvd_next = {dvd_reg[WIDTH-2:0], 1'b1};
        end else begin
          rem_next = shifted;
          dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        dbz_next   = zero_reg;
        if (zero_reg) begin
          // dvd_reg still holds the untouched magnitude, so re-applying the sign restores the dividend.
          quo_next  = '1;
          remo_next = sign_a_reg ? -dvd_reg : dvd_reg;
        end else begin
          quo_next  = (sign_a_reg ^ sign_b_reg) ? -dvd_reg : dvd_reg;
          remo_next = sign_a_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      zero_reg   <= 1'b0;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      quo_reg    <= '0;
      remo_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      zero_reg   <= zero_next;
      dvd_reg    <= dvd_next;
      dsr_reg    <= dsr_next;
      rem_reg    <= rem_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dbz_reg    <= dbz_next;
      quo_reg    <= quo_next;
      remo_reg   <= remo_next;
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = remo_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider at WIDTH=8.
module tb_seq_signed_divider;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_signed_divider_if #(.WIDTH(8)) dif ();

  seq_signed_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.start    = 1'b0;
    dif.dividend = 8'($urandom);
    dif.divisor  = 8'($urandom);
  endtask

  // Returns the number of edges after accept at which done was seen (-1 on timeout).
  task automatic wait_done(input bit noise, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (noise && (n == 2 || n == 4)) begin
        dif.start    = 1'b1;
        dif.dividend = 8'd3;
        dif.divisor  = 8'd1;
      end else begin
        dif.start = 1'b0;
      end
      if (dif.done) begin
        lat = n;
        break;
      end
    end
    dif.start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
    chk({tag, "_q"}, 32'(dif.quotient), 32'(q));
    chk({tag, "_r"}, 32'(dif.remainder), 32'(r));
    chk({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(z));
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                    input logic [7:0] q, input logic [7:0] r, input logic z);
    int lat;
    issue(a, b);
    chk({tag, "_busy"}, 32'(dif.busy), 32'd1);
    wait_done(1'b0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_res(tag, q, r, z);
    chk({tag, "_busy_done"}, 32'(dif.busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(dif.done), 32'd0);
    $display("op %s: a=0x%0h b=0x%0h lat=%0d q=0x%0h r=0x%0h dbz=%0d",
             tag, a, b, lat, dif.quotient, dif.remainder, dif.div_by_zero);
  endtask

  initial begin
    int lat;
    int pulses;
    reset        = 1'b0;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q", 32'(dif.quotient), 32'd0);
    chk("rst_r", 32'(dif.remainder), 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    op("pos",      8'h64, 8'h07, 9, 8'h0E, 8'h02, 1'b0);
    op("neg_dvd",  8'h9C, 8'h07, 9, 8'hF2, 8'hFE, 1'b0);
    op("neg_dsr",  8'h64, 8'hF9, 9, 8'hF2, 8'h02, 1'b0);
    op("neg_both", 8'h9C, 8'hF9, 9, 8'h0E, 8'hFE, 1'b0);
    op("ovf",      8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
    op("min_by1",  8'h80, 8'h01, 9, 8'h80, 8'h00, 1'b0);
    op("small",    8'h05, 8'h09, 9, 8'h00, 8'h05, 1'b0);
    op("equal",    8'h7F, 8'h7F, 9, 8'h01, 8'h00, 1'b0);
    op("dz",       8'hDB, 8'h00, 1, 8'hFF, 8'hDB, 1'b1);
    op("after_dz", 8'h0A, 8'h03, 9, 8'h03, 8'h01, 1'b0);

    // start pulses while busy must be ignored
    issue(8'h64, 8'h07);
    wait_done(1'b1, lat);
    chk("noise_lat", 32'(lat), 32'd9);
    check_res("noise", 8'h0E, 8'h02, 1'b0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (dif.done) pulses++;
    end
    chk("noise_extra_done", 32'(pulses), 32'd0);
    $display("op noise: q=0x%0h r=0x%0h extra_done=%0d", dif.quotient, dif.remainder, pulses);

    // back-to-back: new start in the done cycle
    issue(8'h64, 8'h07);
    wait_done(1'b0, lat);
    chk("b2b_first_lat", 32'(lat), 32'd9);
    check_res("b2b_first", 8'h0E, 8'h02, 1'b0);
    issue(8'd50, 8'd6);
    chk("b2b_done_drop", 32'(dif.done), 32'd0);
    chk("b2b_busy", 32'(dif.busy), 32'd1);
    chk("b2b_hold_q", 32'(dif.quotient), 32'h0E);
    chk("b2b_hold_r", 32'(dif.remainder), 32'h02);
    wait_done(1'b0, lat);
    chk("b2b_second_lat", 32'(lat), 32'd9);
    check_res("b2b_second", 8'h08, 8'h02, 1'b0);
    $display("op b2b: lat=%0d q=0x%0h r=0x%0h", lat, dif.quotient, dif.remainder);
    @(negedge clk);

    // asynchronous reset mid-operation, with div_by_zero set beforehand
    op("dz2", 8'hDB, 8'h00, 1, 8'hFF, 8'hDB, 1'b1);
    issue(8'h64, 8'h07);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(dif.busy), 32'd0);
    chk("arst_done", 32'(dif.done), 32'd0);
    chk("arst_q", 32'(dif.quotient), 32'd0);
    chk("arst_r", 32'(dif.remainder), 32'd0);
    chk("arst_dbz", 32'(dif.div_by_zero), 32'd0);
    $display("op arst: busy=%0d q=0x%0h r=0x%0h dbz=%0d", dif.busy, dif.quotient, dif.remainder, dif.div_by_zero);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (dif.done) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'd0);
    chk("arst_idle_busy", 32'(dif.busy), 32'd0);
    op("post_rst", 8'h64, 8'h07, 9, 8'h0E, 8'h02, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
